// File: rtl/alu_sel_pkg.sv
// Select-code constants shared by the ALU 7-to-1 result mux and the 1-to-7 demux,
// so both ends of the result path use the same encoding.
package alu_sel_pkg;
  localparam int NUM_CH = 7;

  localparam logic [2:0] SEL_CH0   = 3'b000;
  localparam logic [2:0] SEL_CH1   = 3'b001;
  localparam logic [2:0] SEL_CH2   = 3'b011;
  localparam logic [2:0] SEL_CH3   = 3'b100;
  localparam logic [2:0] SEL_CH4   = 3'b110;
  localparam logic [2:0] SEL_CH5   = 3'b101;
  localparam logic [2:0] SEL_CH6   = 3'b111;
  localparam logic [2:0] SEL_UNDEF = 3'b010;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } demux_state_e;
endpackage

// File: rtl/sel_decode_7.sv
// Combinational decoder from a 3-bit ALU select code to {defined, channel index}.
module sel_decode_7
  import alu_sel_pkg::*;
(
  input  logic [2:0] sel_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);

  always_comb begin
    valid_o = 1'b1;
    idx_o   = 3'd0;
    case (sel_i)
      SEL_CH0: idx_o = 3'd0;
      SEL_CH1: idx_o = 3'd1;
      SEL_CH2: idx_o = 3'd2;
      SEL_CH3: idx_o = 3'd3;
      SEL_CH4: idx_o = 3'd4;
      SEL_CH5: idx_o = 3'd5;
      SEL_CH6: idx_o = 3'd6;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/demux_1to7_buffered.sv
// Registered 1-to-7 result demux: one holding register under valid/ready,
// undefined select codes are dropped and counted.
module demux_1to7_buffered
  import alu_sel_pkg::*;
#(
  parameter int size = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [size-1:0]   in_data,
  input  logic [2:0]        in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [size-1:0]   out_data,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic              sel_err,
  output logic [7:0]        err_count
);

  // state | meaning
  // EMPTY | no result held, input always accepted
  // FULL  | result held for channel dest_q, waiting on out_ready[dest_q]

  demux_state_e    state_q, state_d;
  logic [2:0]      dest_q, dest_d;
  logic [size-1:0] data_q, data_d;
  logic [7:0]      err_q, err_d;
  logic            sel_err_q, sel_err_d;

  logic       dec_valid;
  logic [2:0] dec_idx;
  logic       full, drain, accept;

  sel_decode_7 u_dec (
    .sel_i   (in_sel),
    .valid_o (dec_valid),
    .idx_o   (dec_idx)
  );

  assign full     = (state_q == ST_FULL);
  assign drain    = full && out_ready[dest_q];
  assign in_ready = !rst && (!full || out_ready[dest_q]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    data_d    = data_q;
    err_d     = err_q;
    sel_err_d = 1'b0;
    if (accept && dec_valid) begin
      state_d = ST_FULL;
      dest_d  = dec_idx;
      data_d  = in_data;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
    // An undefined code can only be accepted when empty or draining.
    if (accept && !dec_valid) begin
      sel_err_d = 1'b1;
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      dest_q    <= 3'd0;
      data_q    <= '0;
      err_q     <= 8'd0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      data_q    <= data_d;
      err_q     <= err_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (full && (dest_q == 3'(k))) out_valid[k] = 1'b1;
    end
  end

  assign out_data  = data_q;
  assign sel_err   = sel_err_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_demux_1to7_buffered.sv
// Scoreboard bench for demux_1to7_buffered: stimulus pushes expected transfers,
// a negedge monitor pops and compares whenever a channel drains or sel_err pulses.
module tb_demux_1to7_buffered;

  localparam int W = 8;
  localparam int BUDGET = 50;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic [2:0]    in_sel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [6:0]    out_valid;
  logic [6:0]    out_ready = 7'h7F;
  logic          sel_err;
  logic [7:0]    err_count;

  int n_chk = 0;
  int n_fail = 0;
  int err_model = 0;

  logic [10:0] exp_q[$];
  logic [7:0]  err_q[$];

  demux_1to7_buffered #(.size(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_ch(input logic [2:0] sel);
    case (sel)
      3'b000:  return 3'd0;
      3'b001:  return 3'd1;
      3'b011:  return 3'd2;
      3'b100:  return 3'd3;
      3'b110:  return 3'd4;
      3'b101:  return 3'd5;
      default: return 3'd6;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input logic [2:0] sel, input logic [7:0] d, input bit track,
                      output int waited);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    waited   = 0;
    if (track) begin
      if (sel == 3'b010) begin
        err_model = (err_model == 255) ? 255 : err_model + 1;
        err_q.push_back(8'(err_model));
      end else begin
        exp_q.push_back({exp_ch(sel), d});
      end
    end
    @(negedge clk);
    while (!in_ready && waited < BUDGET) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stuck 0 for sel %b", sel);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: a transfer happens on the next edge whenever the addressed channel is ready.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (!rst && ((out_valid & out_ready) != 7'b0)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_drain", {25'b0, out_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("drain_valid", {25'b0, out_valid}, 32'(7'b1 << e[10:8]));
          check("drain_data", {24'b0, out_data}, {24'b0, e[7:0]});
        end
      end
      if (!rst && sel_err) begin
        if (err_q.size() == 0) begin
          check("unexpected_sel_err", {31'b0, sel_err}, 32'h0);
        end else begin
          check("err_count", {24'b0, err_count}, {24'b0, err_q.pop_front()});
        end
      end
    end
  end

  initial begin
    int w;
    logic [2:0] codes [7];
    codes = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};

    // Reset values
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'h0);
    check("rst_out_valid", {25'b0, out_valid}, 32'h0);
    check("rst_out_data", {24'b0, out_data}, 32'h0);
    check("rst_err_count", {24'b0, err_count}, 32'h0);
    check("rst_sel_err", {31'b0, sel_err}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Single transfer to channel 2, latency one cycle
    send(3'b011, 8'hA5, 1'b1, w);
    check("single_valid", {25'b0, out_valid}, 32'h04);
    check("single_data", {24'b0, out_data}, 32'hA5);
    @(posedge clk); #1;
    check("single_empty_after", {25'b0, out_valid}, 32'h0);

    // Stream all channels back to back
    for (int i = 0; i < 7; i++) begin
      send(codes[i], 8'(i + 1), 1'b1, w);
      check("stream_no_stall", 32'(w), 32'h0);
    end
    @(posedge clk); #1;

    // Stall on channel 5, then drain and reload together
    out_ready = 7'b1011111;
    send(3'b101, 8'h3C, 1'b1, w);
    in_valid = 1'b1;
    in_sel   = 3'b000;
    in_data  = 8'h77;
    exp_q.push_back({3'd0, 8'h77});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", {31'b0, in_ready}, 32'h0);
      check("stall_data", {24'b0, out_data}, 32'h3C);
      check("stall_valid", {25'b0, out_valid}, 32'h20);
    end
    @(posedge clk); #1;
    out_ready = 7'h7F;
    @(negedge clk);
    check("reload_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("reload_valid", {25'b0, out_valid}, 32'h01);
    @(posedge clk); #1;

    // Undefined code: dropped, counted, saturating
    send(3'b010, 8'hEE, 1'b1, w);
    check("undef_no_valid", {25'b0, out_valid}, 32'h0);
    check("undef_sel_err", {31'b0, sel_err}, 32'h1);
    check("undef_count1", {24'b0, err_count}, 32'h1);
    for (int i = 1; i < 300; i++) send(3'b010, 8'(i), 1'b1, w);
    @(posedge clk); #1;
    check("undef_sel_err_clear", {31'b0, sel_err}, 32'h0);
    check("err_saturated", {24'b0, err_count}, 32'hFF);

    // Non-addressed ready bits are ignored
    out_ready = 7'b1111011;
    send(3'b011, 8'h42, 1'b1, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ignore_other_valid", {25'b0, out_valid}, 32'h04);
      check("ignore_other_ready", {31'b0, in_ready}, 32'h0);
    end
    @(posedge clk); #1;
    out_ready = 7'h7F;
    @(posedge clk); #1;
    check("ignore_drained", {25'b0, out_valid}, 32'h0);

    // Async reset mid-transfer discards the held result
    out_ready = 7'b0111111;
    send(3'b111, 8'h66, 1'b0, w);
    check("hold_ch6", {25'b0, out_valid}, 32'h40);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", {25'b0, out_valid}, 32'h0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 7'h7F;
    err_model = 0;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("post_rst_err_count", {24'b0, err_count}, 32'h0);
    check("post_rst_valid", {25'b0, out_valid}, 32'h0);

    repeat (3) @(posedge clk);
    check("exp_queue_empty", 32'(exp_q.size()), 32'h0);
    check("err_queue_empty", 32'(err_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1to7_buffered.md
# demux_1to7_buffered

Registered 1-to-7 demultiplexer that routes one `size`-bit ALU result to one of seven destination channels, using the same 3-bit select encoding as the ALU's 7-to-1 operand/result mux. It sits on the ALU result path, after the result mux and ahead of the per-destination consumers. It holds one result in an output register under a valid/ready handshake. Undefined select codes are rejected and counted.

## Interface
- `size`, 1, data width in bits
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `in_data`  input  size  result to route
- `in_sel`  input  3  destination select code, defined under Operation
- `in_valid`  input  1  `in_data`/`in_sel` are valid
- `in_ready`  output  1  block accepts the input this cycle
- `out_data`  output  size  registered result, shared by all channels
- `out_valid`  output  7  one-hot; bit k means channel k holds the result
- `out_ready`  input  7  per-channel consumer ready
- `sel_err`  output  1  one-cycle pulse: an undefined code was accepted and dropped
- `err_count`  output  8  saturating count of dropped inputs

## Operation
- Select code to channel map: 000→0, 001→1, 011→2, 100→3, 110→4, 101→5, 111→6. Code 010 is undefined.
- States:
  - EMPTY: `full`=0.
  - FULL: `full`=1, `dest` register holds a channel index 0–6.
- `in_ready` = !rst && (!full || out_ready[dest]), combinational.
- Accept = in_valid && in_ready.
- Drain = full && out_ready[dest]. Only the `out_ready` bit of the addressed channel matters; all other bits are ignored.
- Valid code accepted: `out_data`←in_data, `dest`←mapped index, `full`←1.
- Undefined code (010) accepted: the data is discarded, and on the next edge `sel_err`=1 and `err_count` increments. `err_count` saturates at 255.
- Drain with no valid accept in the same cycle: `full`←0. `out_data` keeps its last value.
- Drain and valid accept in the same cycle: the register is reloaded, `full` stays 1, and `dest` may change. This sustains one result per cycle.
- Drain and undefined accept in the same cycle: `full`←0 and `sel_err` pulses.
- `out_valid[k]` = full && (dest==k), registered-derived, so it is never glitchy from inputs. At most one bit is set.
- While FULL and the addressed channel is not ready, `out_data` and `out_valid` hold stable. `in_ready`=0, so the input is stalled.

## Timing
- Reset values (asynchronous): `full`=0, `dest`=0, `out_data`=0, `out_valid`=7'b0, `sel_err`=0, `err_count`=0. `in_ready`=0 while `rst`=1.
- Latency: accept on edge N gives `out_valid` high in cycle N+1.
- Throughput: 1 transfer per cycle when the addressed consumer is ready every cycle.
- `sel_err` is high for exactly one cycle per dropped input. Back-to-back drops hold it high across consecutive cycles.
- Reset asserted mid-transfer discards the held result. `out_valid` falls immediately and asynchronously, with no partial drain.
- When `in_valid`=0, `in_sel` and `in_data` are don't-care and cause no state change.

## Structure
- Shared package `alu_sel_pkg`:
  - Select-code localparams `SEL_CH0`…`SEL_CH6` (000, 001, 011, 100, 110, 101, 111) and `SEL_UNDEF`=3'b010.
  - `NUM_CH`=7.
  - These constants are shared with the 7-to-1 result mux so both ends stay consistent.
- One sub-module, `sel_decode_7`: combinational decoder from code to {valid bit, 3-bit index}. It is reusable by any consumer of the encoding.
- All other logic stays in the top module: one holding register, `dest`, `full`, and the error counter.

## Test plan
- Reset, then `in_sel`=011 with `in_data`=1 (size=8: 8'hA5), `out_ready`=7'h7F → next cycle `out_valid`=7'b0000100 and `out_data`=8'hA5. The following cycle `out_valid`=0.
- Stream codes 000, 001, 011, 100, 110, 101, 111 on consecutive cycles with data 1–7, all ready → `out_valid` walks bits 0–6 at one per cycle and `in_ready` stays 1 throughout.
- Accept code 101 with data 8'h3C while `out_ready[5]`=0 for 4 cycles, holding `in_valid`=1 with new data → `in_ready`=0 and `out_data`=8'h3C stay stable. Raise `out_ready[5]` → drain and reload in the same cycle.
- `in_sel`=010 with `in_valid`=1 → no `out_valid` bit set, one-cycle `sel_err` pulse, `err_count`=1. After 300 such inputs, `err_count`=255.
- Hold a result for channel 6 and assert `rst` asynchronously mid-cycle → `out_valid`=0 before the next edge, and after release `in_ready`=1 with `err_count`=0.
- With channel 2 holding a result, `out_ready`=7'b1111011 → no drain, because non-addressed ready bits are ignored.
